// File: rtl/ptr_release_mgr.sv
// ptr_release_mgr: reference-count manager for shared packet-buffer pointers.
// Ports register a pointer with its fan-out count; output ports release it one
// at a time, and the pointer is handed back to the free queue when its count
// reaches zero. Optional build macro RELEASE_STATS_EN adds two 16-bit
// wrap-around activity counters (stat_freed, stat_releases).
module ptr_release_mgr #(
    parameter int PORTS = 4,
    parameter int PTR_W = 10,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   set_valid,
    input  logic [PTR_W-1:0]       set_ptr,
    input  logic [CNT_W-1:0]       set_cnt,
    output logic                   set_ready,
    input  logic [PORTS-1:0]       rel_req,
    input  logic [PORTS*PTR_W-1:0] rel_ptr,
    output logic [PORTS-1:0]       rel_ack,
    output logic                   fq_wr,
    output logic [15:0]            fq_ptr,
    output logic                   init_done,
    output logic                   err_underflow,
    output logic                   err_zero_set
`ifdef RELEASE_STATS_EN
    ,
    output logic [15:0]            stat_freed,
    output logic [15:0]            stat_releases
`endif
);

    localparam int IDX_W = $clog2(PORTS);
    localparam int DEPTH = 1 << PTR_W;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_UPD} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt_ram [DEPTH];
    logic [CNT_W-1:0]  rd_cnt;
    logic [PTR_W-1:0]  init_addr;
    logic [PTR_W-1:0]  lat_ptr;
    logic [IDX_W-1:0]  rr_pri;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic              ram_we;
    logic [PTR_W-1:0]  ram_waddr;
    logic [CNT_W-1:0]  ram_wdata;
    logic              free_fire;
    logic              underflow_hit;
    logic              grant_fire;
    logic              set_fire;
    logic [15:0]       fq_ptr_nxt;

    // Round-robin search starting at the current highest-priority port.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < PORTS; k++) begin
            idx = int'(rr_pri) + k;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!win_found && rel_req[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rstn) state <= S_INIT;
        else       state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_addr == {PTR_W{1'b1}}) state_nxt = S_IDLE;
            S_IDLE:  if (win_found) state_nxt = S_RD;
            S_RD:    state_nxt = S_UPD;
            S_UPD:   state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    // FSM outputs: set handshake and the single count-RAM write port.
    always_comb begin
        set_ready     = 1'b0;
        ram_we        = 1'b0;
        ram_waddr     = lat_ptr;
        ram_wdata     = '0;
        free_fire     = 1'b0;
        underflow_hit = 1'b0;
        case (state)
            S_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = init_addr;
            end
            S_IDLE: begin
                set_ready = 1'b1;
                if (set_valid) begin
                    ram_we    = 1'b1;
                    ram_waddr = set_ptr;
                    ram_wdata = set_cnt;
                end
            end
            S_UPD: begin
                if (rd_cnt == '0) begin
                    underflow_hit = 1'b1;
                end else begin
                    ram_we    = 1'b1;
                    ram_wdata = rd_cnt - CNT_W'(1);
                    free_fire = (rd_cnt == CNT_W'(1));
                end
            end
            default: ;
        endcase
    end

    assign set_fire   = set_valid && set_ready;
    assign grant_fire = (state == S_IDLE) && win_found;

    // Zero-extend the latched pointer onto the 16-bit free-queue bus.
    always_comb begin
        fq_ptr_nxt              = '0;
        fq_ptr_nxt[PTR_W-1:0]   = lat_ptr;
    end

    // Count RAM: one write port, registered read of the latched pointer.
    always_ff @(posedge clk) begin
        // NOTE: the RAM has no reset; the INIT sweep clears it instead,
        // which keeps it mappable onto block memory.
        if (ram_we) cnt_ram[ram_waddr] <= ram_wdata;
        rd_cnt <= cnt_ram[lat_ptr];
    end

    // Control registers: init sweep, grant latch, RR priority, outputs, flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            init_addr     <= '0;
            lat_ptr       <= '0;
            rr_pri        <= '0;
            rel_ack       <= '0;
            fq_wr         <= 1'b0;
            fq_ptr        <= '0;
            init_done     <= 1'b0;
            err_underflow <= 1'b0;
            err_zero_set  <= 1'b0;
        end else begin
            if (state == S_INIT) init_addr <= init_addr + PTR_W'(1);
            if (state != S_INIT) init_done <= 1'b1;
            rel_ack <= '0;
            if (grant_fire) begin
                lat_ptr <= rel_ptr[win_idx*PTR_W +: PTR_W];
                rel_ack <= PORTS'(1) << win_idx;
                rr_pri  <= (win_idx == IDX_W'(PORTS-1)) ? '0 : win_idx + IDX_W'(1);
            end
            fq_wr <= free_fire;
            if (free_fire) fq_ptr <= fq_ptr_nxt;
            if (underflow_hit) err_underflow <= 1'b1;
            if (set_fire && set_cnt == '0) err_zero_set <= 1'b1;
        end
    end

`ifdef RELEASE_STATS_EN
    // Activity counters; both wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_freed    <= '0;
            stat_releases <= '0;
        end else begin
            if (free_fire)  stat_freed    <= stat_freed + 16'd1;
            if (grant_fire) stat_releases <= stat_releases + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ptr_release_mgr.sv
// Directed testbench for ptr_release_mgr with a reference-count model and
// scoreboard queues for expected grants and free-queue writes.
module tb_ptr_release_mgr;

    localparam int PORTS = 4;
    localparam int PTR_W = 10;
    localparam int CNT_W = 4;

    logic                   clk;
    logic                   rstn;
    logic                   set_valid;
    logic [PTR_W-1:0]       set_ptr;
    logic [CNT_W-1:0]       set_cnt;
    logic                   set_ready;
    logic [PORTS-1:0]       rel_req;
    logic [PORTS*PTR_W-1:0] rel_ptr;
    logic [PORTS-1:0]       rel_ack;
    logic                   fq_wr;
    logic [15:0]            fq_ptr;
    logic                   init_done;
    logic                   err_underflow;
    logic                   err_zero_set;
`ifdef RELEASE_STATS_EN
    logic [15:0]            stat_freed;
    logic [15:0]            stat_releases;
`endif

    ptr_release_mgr #(.PORTS(PORTS), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .set_valid     (set_valid),
        .set_ptr       (set_ptr),
        .set_cnt       (set_cnt),
        .set_ready     (set_ready),
        .rel_req       (rel_req),
        .rel_ptr       (rel_ptr),
        .rel_ack       (rel_ack),
        .fq_wr         (fq_wr),
        .fq_ptr        (fq_ptr),
        .init_done     (init_done),
        .err_underflow (err_underflow),
        .err_zero_set  (err_zero_set)
`ifdef RELEASE_STATS_EN
        ,
        .stat_freed    (stat_freed),
        .stat_releases (stat_releases)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ptr;
        int          due;
    } fq_exp_t;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc     = 0;
    int               n_fq    = 0;
    int               n_grant = 0;
    fq_exp_t          exp_fq[$];
    int               exp_ack[$];
    int               ack_log[$];
    logic [PTR_W-1:0] port_q [PORTS][$];
    int               model_cnt [1 << PTR_W];
    logic             exp_underflow = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pending();
        int n = exp_fq.size() + exp_ack.size();
        for (int i = 0; i < PORTS; i++) n += port_q[i].size();
        return n;
    endfunction

    // One clock: sample on the falling edge, score fq_wr and grants, and let
    // each granted requester move on to its next queued pointer.
    task automatic step();
        int               p;
        logic [PTR_W-1:0] ptr;
        fq_exp_t          e;
        @(negedge clk);
        cyc++;
        if (fq_wr) begin
            n_fq++;
            if (exp_fq.size() == 0) begin
                check("fq_wr_unexpected", {31'b0, fq_wr}, 32'd0);
            end else begin
                e = exp_fq.pop_front();
                check("fq_ptr", {16'b0, fq_ptr}, {16'b0, e.ptr});
                check("fq_cycle", cyc, e.due);
            end
        end else if (exp_fq.size() != 0 && exp_fq[0].due <= cyc) begin
            e = exp_fq.pop_front();
            check("fq_wr_missing", {31'b0, fq_wr}, 32'd1);
        end
        if (rel_ack != '0) begin
            n_grant++;
            check("ack_onehot", {31'b0, $onehot(rel_ack)}, 32'd1);
            p = 0;
            for (int i = 0; i < PORTS; i++) if (rel_ack[i]) p = i;
            if (exp_ack.size() == 0) check("ack_unexpected", {28'b0, rel_ack}, 32'd0);
            else                     check("ack_port", p, exp_ack.pop_front());
            ack_log.push_back(cyc);
            if (port_q[p].size() != 0) begin
                ptr = port_q[p].pop_front();
                if (model_cnt[ptr] == 0) begin
                    exp_underflow = 1'b1;
                end else if (model_cnt[ptr] == 1) begin
                    model_cnt[ptr] = 0;
                    exp_fq.push_back('{ptr: {6'b0, ptr}, due: cyc + 2});
                end else begin
                    model_cnt[ptr] = model_cnt[ptr] - 1;
                end
            end
            if (port_q[p].size() != 0) rel_ptr[p*PTR_W +: PTR_W] = port_q[p][0];
            else                       rel_req[p] = 1'b0;
        end
    endtask

    task automatic do_set(input logic [PTR_W-1:0] ptr, input logic [CNT_W-1:0] cnt);
        int budget = 50;
        set_valid = 1'b1;
        set_ptr   = ptr;
        set_cnt   = cnt;
        while (!set_ready && budget > 0) begin
            step();
            budget--;
        end
        check("set_ready_seen", {31'b0, set_ready}, 32'd1);
        step();
        set_valid = 1'b0;
        model_cnt[ptr] = int'(cnt);
    endtask

    task automatic queue_rel(input int p, input logic [PTR_W-1:0] ptr);
        port_q[p].push_back(ptr);
        if (!rel_req[p]) begin
            rel_req[p] = 1'b1;
            rel_ptr[p*PTR_W +: PTR_W] = ptr;
        end
    endtask

    task automatic drain(input string tag);
        int budget = 300;
        while (pending() != 0 && budget > 0) begin
            step();
            budget--;
        end
        check({tag, "_drained"}, pending(), 0);
        repeat (3) step();
    endtask

    task automatic check_spacing(input string tag);
        for (int i = 1; i < ack_log.size(); i++)
            check(tag, ack_log[i] - ack_log[i-1], 3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_set_ready"}, {31'b0, set_ready}, 32'd0);
        check({tag, "_rel_ack"},   {28'b0, rel_ack}, 32'd0);
        check({tag, "_fq_wr"},     {31'b0, fq_wr}, 32'd0);
        check({tag, "_fq_ptr"},    {16'b0, fq_ptr}, 32'd0);
        check({tag, "_init_done"}, {31'b0, init_done}, 32'd0);
        check({tag, "_err_uf"},    {31'b0, err_underflow}, 32'd0);
        check({tag, "_err_zs"},    {31'b0, err_zero_set}, 32'd0);
`ifdef RELEASE_STATS_EN
        check({tag, "_stat_freed"}, {16'b0, stat_freed}, 32'd0);
        check({tag, "_stat_rel"},   {16'b0, stat_releases}, 32'd0);
`endif
    endtask

    // Release reset and watch the clear sweep: quiet for 1024 cycles,
    // init_done visible after the 1025th edge.
    task automatic wait_init(input string tag);
        int bad = 0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 1; i <= 1024; i++) begin
            step();
            if (init_done || rel_ack != '0 || fq_wr) bad++;
            if (i < 1024 && set_ready) bad++;
        end
        check({tag, "_quiet"}, bad, 0);
        check({tag, "_done_at_1024"}, {31'b0, init_done}, 32'd0);
        step();
        check({tag, "_done_at_1025"}, {31'b0, init_done}, 32'd1);
    endtask

    initial begin
        int t0;
        int fq0;
        int budget;
        rstn      = 1'b0;
        set_valid = 1'b0;
        set_ptr   = '0;
        set_cnt   = '0;
        rel_req   = '0;
        rel_ptr   = '0;
        for (int i = 0; i < (1 << PTR_W); i++) model_cnt[i] = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        wait_init("init");

        // Single-count pointer released by port 2.
        do_set(10'h005, 4'd1);
        ack_log.delete();
        t0 = cyc;
        queue_rel(2, 10'h005);
        exp_ack.push_back(2);
        drain("single");
        check("single_ack_latency", ack_log[0] - t0, 1);
        check("single_no_underflow", {31'b0, err_underflow}, 32'd0);

        // Release of a pointer never set after INIT; also moves RR priority to 0.
        fq0 = n_fq;
        queue_rel(3, 10'h020);
        exp_ack.push_back(3);
        drain("underflow");
        check("underflow_flag", {31'b0, err_underflow}, {31'b0, exp_underflow});
        check("underflow_no_fq", n_fq - fq0, 0);
        repeat (5) step();
        check("underflow_sticky", {31'b0, err_underflow}, 32'd1);

        // Count-3 pointer released by ports 0, 1, 3 at once.
        do_set(10'h01A, 4'd3);
        ack_log.delete();
        fq0 = n_fq;
        queue_rel(0, 10'h01A);
        queue_rel(1, 10'h01A);
        queue_rel(3, 10'h01A);
        exp_ack.push_back(0);
        exp_ack.push_back(1);
        exp_ack.push_back(3);
        drain("fanout3");
        check_spacing("fanout3_spacing");
        check("fanout3_one_fq", n_fq - fq0, 1);

        // All four ports requesting continuously: grants rotate 0,1,2,3,0,...
        for (int p = 0; p < PORTS; p++)
            for (int k = 0; k < 2; k++) do_set(PTR_W'(10'h100 + p*2 + k), 4'd1);
        ack_log.delete();
        fq0 = n_fq;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < PORTS; p++) begin
                queue_rel(p, PTR_W'(10'h100 + p*2 + k));
                exp_ack.push_back(p);
            end
        drain("rotate4");
        check_spacing("rotate4_spacing");
        check("rotate4_fq_count", n_fq - fq0, 8);

        // Only ports 1 and 3 requesting: grants alternate 1,3.
        for (int k = 0; k < 4; k++) do_set(PTR_W'(10'h200 + k), 4'd1);
        ack_log.delete();
        fq0 = n_fq;
        queue_rel(1, 10'h200);
        queue_rel(3, 10'h201);
        queue_rel(1, 10'h202);
        queue_rel(3, 10'h203);
        exp_ack.push_back(1);
        exp_ack.push_back(3);
        exp_ack.push_back(1);
        exp_ack.push_back(3);
        drain("alt13");
        check_spacing("alt13_spacing");
        check("alt13_fq_count", n_fq - fq0, 4);

        // Zero-count set raises the sticky flag.
        check("zero_set_before", {31'b0, err_zero_set}, 32'd0);
        do_set(10'h030, 4'd0);
        check("zero_set_flag", {31'b0, err_zero_set}, 32'd1);
`ifdef RELEASE_STATS_EN
        check("stat_releases", {16'b0, stat_releases}, n_grant);
        check("stat_freed", {16'b0, stat_freed}, n_fq);
`endif

        // Reset asserted while a count-1 release is in RD.
        do_set(10'h040, 4'd1);
        ack_log.delete();
        queue_rel(0, 10'h040);
        exp_ack.push_back(0);
        budget = 20;
        while (ack_log.size() == 0 && budget > 0) begin
            step();
            budget--;
        end
        check("rd_reached", ack_log.size(), 1);
        rstn = 1'b0;
        #1;
        exp_fq.delete();
        exp_ack.delete();
        for (int p = 0; p < PORTS; p++) port_q[p].delete();
        rel_req = '0;
        for (int i = 0; i < (1 << PTR_W); i++) model_cnt[i] = 0;
        check_reset_outputs("midreset");
        fq0 = n_fq;
        repeat (3) step();
        wait_init("reinit");
        repeat (5) step();
        check("midreset_no_fq", n_fq - fq0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so a stuck DUT still ends the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed no completion, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ptr_release_mgr.md
# ptr_release_mgr

Reference-count manager for shared packet-buffer pointers, sitting directly upstream of the free-pointer queue. The enqueue side registers each stored frame's pointer with its fan-out count (number of output ports holding it). Output ports release pointers after transmission. When a pointer's count reaches zero, the block writes it back into the free queue through its `FQ_wr`/`ptr_din` write port.

## Interface
Parameters:
- `PORTS`, 4: number of releasing output ports (2..8).
- `PTR_W`, 10: pointer width; count RAM depth is 2^PTR_W.
- `CNT_W`, 4: reference-count width.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `set_valid` in 1: register a pointer's count.
- `set_ptr` in PTR_W: pointer being registered.
- `set_cnt` in CNT_W: fan-out count (1..2^CNT_W-1).
- `set_ready` out 1: set accepted when `set_valid && set_ready`.
- `rel_req` in PORTS: per-port release request, held until acked.
- `rel_ptr` in PORTS*PTR_W: per-port pointer; port i uses bits [i*PTR_W +: PTR_W].
- `rel_ack` out PORTS: one-hot, one-cycle grant pulse.
- `fq_wr` out 1: one-cycle pulse returning a pointer to the free queue.
- `fq_ptr` out 16: `{zero pad, pointer}`; connects to the free queue's `ptr_din`.
- `init_done` out 1: high once the count RAM clear has finished.
- `err_underflow` out 1: sticky; a release hit a count of 0.
- `err_zero_set` out 1: sticky; a set arrived with `set_cnt == 0`.

## Operation
- Internal count RAM: 2^PTR_W x CNT_W, one write port, registered read (1-cycle latency).
- FSM states: INIT, IDLE, RD, UPD.
- INIT:
  - Entered on reset.
  - Writes 0 to addresses 0..2^PTR_W-1, one per cycle.
  - After the last address: `init_done` goes to 1 and the FSM goes to IDLE.
  - No grants and `set_ready` = 0 during INIT.
- IDLE:
  - `set_ready` = 1. An accepted set writes `ram[set_ptr] <= set_cnt` on that edge.
  - `set_cnt == 0`: the write is still performed, and `err_zero_set` is set.
  - If any `rel_req` bit is set: round-robin grant, latch the winner's pointer and index, go to RD.
  - A set and a grant in the same IDLE cycle are both performed.
- RD: RAM read of the latched pointer is issued; `set_ready` = 0.
- UPD:
  - Count c available; `set_ready` = 0.
  - c == 0: no write, no `fq_wr`, set `err_underflow`.
  - c == 1: write 0 and pulse `fq_wr` with the pointer.
  - c > 1: write c-1.
  - Then go to IDLE.
- Round-robin:
  - After reset, port 0 has highest priority.
  - After granting port i, highest priority moves to (i+1) mod PORTS.
  - Non-requesting ports are skipped.
- Setting a pointer that is currently in RD/UPD is a system protocol violation. Result: the last RAM write wins.
- Free-queue backpressure does not exist: at most 2^PTR_W pointers exist, so the free queue never overflows.

## Timing
- Reset values:
  - `set_ready` 0, `rel_ack` 0, `fq_wr` 0, `fq_ptr` 0.
  - `init_done` 0, both error flags 0.
  - FSM in INIT, RR priority at port 0.
  - RAM contents undefined until the INIT sweep finishes.
- INIT lasts 2^PTR_W cycles after reset release; `init_done` is registered and rises on the following edge.
- Release, with `rel_req[i]` sampled in IDLE at cycle T:
  - `rel_ack[i]` = 1 during T+1 only (RD).
  - UPD at T+2.
  - `fq_wr`/`fq_ptr` registered, valid during T+3.
  - FSM back in IDLE at T+3.
  - Throughput: one release per 3 cycles.
- Requester drops `rel_req` the cycle after seeing `rel_ack`. The next arbitration is at T+3, so no double grant occurs.
- `fq_wr` is never asserted on consecutive cycles.
- Asynchronous reset mid-operation: in-flight release is discarded, no `fq_wr`, FSM restarts INIT.

## Configuration
- `RELEASE_STATS_EN` defined adds outputs `stat_freed` [15:0] and `stat_releases` [15:0]:
  - Both reset to 0.
  - `stat_freed` increments on each `fq_wr`; `stat_releases` on each grant.
  - Both wrap at 16'hFFFF -> 0.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then wait: `init_done` rises 2^PTR_W+1 cycles after reset release (1025 at default). No `rel_ack` or `fq_wr` before it.
- Set ptr 0x05, cnt 1; port 2 releases 0x05:
  - `rel_ack[2]` pulses one cycle later.
  - `fq_wr`=1 with `fq_ptr`=16'h0005 at T+3.
- Set ptr 0x1A, cnt 3; ports 0, 1, 3 release 0x1A simultaneously:
  - Acks in order 0, 1, 3, 3 cycles apart.
  - Exactly one `fq_wr` (`fq_ptr`=16'h001A), after the third release.
- Release ptr 0x20 that was never set after INIT: `err_underflow`=1, no `fq_wr`, flag stays high.
- All four ports request continuously with distinct single-count pointers: grants rotate 0, 1, 2, 3, 0 with 3-cycle spacing. Repeat with only ports 1 and 3 requesting: grants alternate 1, 3.
- Pull `rstn` low during RD of a cnt-1 pointer: no `fq_wr`, outputs at reset values, INIT restarts. With `RELEASE_STATS_EN`, both counters read 0.
